// File: rtl/mc_control_fsm.sv
// Main control FSM for the multi-cycle MIPS datapath: Moore decode of the current
// state into register enables and mux selects. Define MC_MEM_WAIT_EN for memory wait states.
module mc_control_fsm #(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
`ifdef MC_MEM_WAIT_EN
    input  logic            mem_ready,
`endif
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            mem_to_reg,
    output logic            reg_dst,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_source,
    output logic [ST_W-1:0] state
);

    typedef enum logic [ST_W-1:0] {
        S_FETCH     = ST_W'(0),
        S_DECODE    = ST_W'(1),
        S_MEM_ADDR  = ST_W'(2),
        S_MEM_READ  = ST_W'(3),
        S_MEM_WB    = ST_W'(4),
        S_MEM_WRITE = ST_W'(5),
        S_EXECUTE   = ST_W'(6),
        S_ALU_WB    = ST_W'(7),
        S_BRANCH    = ST_W'(8),
        S_JUMP      = ST_W'(9),
        S_ADDI_EX   = ST_W'(10),
        S_ADDI_WB   = ST_W'(11)
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_v;
    logic   mem_rdy;
    logic   fetch_wait;

`ifdef MC_MEM_WAIT_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    // Control word for a given state; unused codes decode to all zeros.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEM_ADDR, S_ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_ALU_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_source     = 2'b01;
                c.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                c.pc_source = 2'b10;
                c.pc_write  = 1'b1;
            end
            S_ADDI_WB: c.reg_write = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = mem_rdy ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_rdy ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_d = S_ALU_WB;
            S_ADDI_EX:   state_d = S_ADDI_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    // Control word is registered alongside the state so outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= ctrl_of(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_of(state_d);
        end
    end

    // Reset blanks every strobe immediately; a fetch waiting on memory must not latch IR or bump PC.
    assign ctrl_v     = reset ? '0 : ctrl_q;
    assign fetch_wait = (state_q == S_FETCH) && !mem_rdy;

    assign pc_write      = ctrl_v.pc_write && !fetch_wait;
    assign ir_write      = ctrl_v.ir_write && !fetch_wait;
    assign pc_write_cond = ctrl_v.pc_write_cond;
    assign iord          = ctrl_v.iord;
    assign mem_read      = ctrl_v.mem_read;
    assign mem_write     = ctrl_v.mem_write;
    assign mem_to_reg    = ctrl_v.mem_to_reg;
    assign reg_dst       = ctrl_v.reg_dst;
    assign reg_write     = ctrl_v.reg_write;
    assign alu_src_a     = ctrl_v.alu_src_a;
    assign alu_src_b     = ctrl_v.alu_src_b;
    assign alu_op        = ctrl_v.alu_op;
    assign pc_source     = ctrl_v.pc_source;
    assign state         = state_q;

    a_mem_excl: assert property (@(posedge clk) !(mem_read && mem_write));
    a_wr_excl:  assert property (@(posedge clk) !(reg_write && ir_write));

endmodule
